// File: rtl/i3c_tb_fifo_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// i3c_tb_fifo_arbiter_pkg
// Shared definitions for the TX FIFO write-port arbiter:
//   - arb_state_e : 2-bit sequencer state encoding
//   - default parameter values for requester count, owner width and watchdog
// No ports (package).
// ----------------------------------------------------------------------------
package i3c_tb_fifo_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_XFER  = 2'd1,
        ARB_FLUSH = 2'd2,
        ARB_RECOV = 2'd3
    } arb_state_e;

    localparam int ARB_NREQ_DEF    = 3;
    localparam int ARB_OWB_DEF     = 2;
    localparam int ARB_TIMEOUT_DEF = 255;
    localparam int ARB_TOB_DEF     = 8;

endpackage : i3c_tb_fifo_arbiter_pkg

// File: rtl/i3c_tb_fifo_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// i3c_tb_fifo_arbiter_rr_pick
// Combinational round-robin picker. Chooses the lowest requesting index that
// is >= ptr_i; if none exists, wraps and chooses the lowest requesting index.
// Ports:
//   req_i   in  NREQ  request vector
//   ptr_i   in  OWB   round-robin start index
//   pick_o  out OWB   chosen index (0 when no request)
//   any_o   out 1     at least one request present
// ----------------------------------------------------------------------------
module i3c_tb_fifo_arbiter_rr_pick
    import i3c_tb_fifo_arbiter_pkg::*;
#(
    parameter int NREQ = ARB_NREQ_DEF,
    parameter int OWB  = ARB_OWB_DEF
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [OWB-1:0]  ptr_i,
    output logic [OWB-1:0]  pick_o,
    output logic            any_o
);

    logic [OWB-1:0] hi_idx_s;
    logic [OWB-1:0] lo_idx_s;
    logic           hi_found_s;

    // Scan downwards so the last hit written is the lowest qualifying index.
    always_comb begin
        hi_idx_s   = '0;
        lo_idx_s   = '0;
        hi_found_s = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            lo_idx_s   = req_i[i] ? OWB'(i) : lo_idx_s;
            hi_idx_s   = (req_i[i] && (OWB'(i) >= ptr_i)) ? OWB'(i) : hi_idx_s;
            hi_found_s = (req_i[i] && (OWB'(i) >= ptr_i)) ? 1'b1 : hi_found_s;
        end
        pick_o = hi_found_s ? hi_idx_s : lo_idx_s;
        any_o  = |req_i;
    end

endmodule : i3c_tb_fifo_arbiter_rr_pick

// File: rtl/i3c_tb_fifo_arbiter.sv
// ----------------------------------------------------------------------------
// i3c_tb_fifo_arbiter
// Arbiter/sequencer in front of the TX FIFO write port. NREQ byte-stream
// requesters share one push interface; a granted requester keeps the FIFO
// until its last byte is pushed. Also sequences FIFO flushes and watches for
// an owner that stalls mid-message.
// Ports:
//   clk_i            in   system clock
//   rst_ni           in   async active-low reset
//   req_valid_i      in   NREQ    requester i has a byte
//   req_data_i       in   8*NREQ  byte of requester i at [8*i +: 8]
//   req_last_i       in   NREQ    byte is last of message (qualified by valid)
//   req_ready_o      out  NREQ    byte of requester i accepted this cycle
//   avail_tb_ready_o out  1       push request to the FIFO
//   avail_tb_data_o  out  8       byte to the FIFO
//   avail_tb_end_o   out  1       end-of-message flag to the FIFO
//   avail_tb_full_i  in   1       FIFO full
//   tb_flush_o       out  1       one-cycle FIFO flush pulse
//   flush_req_i      in   1       flush request pulse
//   err_clr_i        in   1       clears timeout_err_o
//   busy_o           out  1       sequencer not idle
//   owner_o          out  OWB     current/last grantee
//   msg_done_o       out  1       last byte of a message pushed
//   timeout_err_o    out  1       sticky watchdog error
// ----------------------------------------------------------------------------
module i3c_tb_fifo_arbiter
    import i3c_tb_fifo_arbiter_pkg::*;
#(
    parameter int NREQ    = ARB_NREQ_DEF,
    parameter int OWB     = ARB_OWB_DEF,
    parameter int TIMEOUT = ARB_TIMEOUT_DEF,
    parameter int TOB     = ARB_TOB_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [8*NREQ-1:0] req_data_i,
    input  logic [NREQ-1:0]   req_last_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic              avail_tb_ready_o,
    output logic [7:0]        avail_tb_data_o,
    output logic              avail_tb_end_o,
    input  logic              avail_tb_full_i,
    output logic              tb_flush_o,
    input  logic              flush_req_i,
    input  logic              err_clr_i,
    output logic              busy_o,
    output logic [OWB-1:0]    owner_o,
    output logic              msg_done_o,
    output logic              timeout_err_o
);

    localparam logic           WD_EN   = (TIMEOUT != 0);
    localparam logic [TOB-1:0] WD_LAST = TOB'(TIMEOUT - 1);

    arb_state_e     state_q;
    logic [OWB-1:0] owner_q;
    logic [OWB-1:0] rr_ptr_q;
    logic [TOB-1:0] wd_cnt_q;
    logic           timeout_err_q;

    logic           own_valid_s;
    logic           own_last_s;
    logic [7:0]     own_data_s;
    logic           xfer_s;
    logic           push_s;
    logic           stall_s;
    logic           wd_fire_s;
    logic           msg_done_s;
    logic [OWB-1:0] pick_s;
    logic           pick_any_s;

    i3c_tb_fifo_arbiter_rr_pick #(
        .NREQ (NREQ),
        .OWB  (OWB)
    ) u_rr_pick (
        .req_i  (req_valid_i),
        .ptr_i  (rr_ptr_q),
        .pick_o (pick_s),
        .any_o  (pick_any_s)
    );

    // Select the owner's valid/last/data lanes.
    always_comb begin
        own_valid_s = 1'b0;
        own_last_s  = 1'b0;
        own_data_s  = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (OWB'(i) == owner_q) begin
                own_valid_s = req_valid_i[i];
                own_last_s  = req_last_i[i];
                own_data_s  = req_data_i[8*i +: 8];
            end else begin
                own_valid_s = own_valid_s;
            end
        end
    end

    assign xfer_s  = (state_q == ARB_XFER);
    assign push_s  = xfer_s & own_valid_s & ~avail_tb_full_i;
    // A full FIFO with a valid owner is back-pressure, not a stall.
    assign stall_s = xfer_s & ~own_valid_s;
    assign wd_fire_s = WD_EN & stall_s & (wd_cnt_q == WD_LAST);
    // A same-cycle flush request discards the message, so no completion.
    assign msg_done_s = push_s & own_last_s & ~flush_req_i;

    // Push-side outputs; only the owner ever sees ready.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_ready_o[i] = push_s & (OWB'(i) == owner_q);
        end
        avail_tb_ready_o = xfer_s & own_valid_s;
        avail_tb_data_o  = xfer_s ? own_data_s : 8'h00;
        avail_tb_end_o   = xfer_s & own_valid_s & own_last_s;
    end

    assign tb_flush_o    = (state_q == ARB_FLUSH);
    assign busy_o        = (state_q != ARB_IDLE);
    assign owner_o       = owner_q;
    assign msg_done_o    = msg_done_s;
    assign timeout_err_o = timeout_err_q;

    // Sequencer: grant, transfer, watchdog, flush and recovery.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ARB_IDLE;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            // Watchdog set wins over a same-cycle clear.
            if (wd_fire_s) begin
                timeout_err_q <= 1'b1;
            end else if (err_clr_i) begin
                timeout_err_q <= 1'b0;
            end else begin
                timeout_err_q <= timeout_err_q;
            end

            case (state_q)
                ARB_IDLE: begin
                    wd_cnt_q <= '0;
                    if (flush_req_i) begin
                        state_q <= ARB_FLUSH;
                    end else if (pick_any_s) begin
                        owner_q <= pick_s;
                        state_q <= ARB_XFER;
                    end else begin
                        state_q <= ARB_IDLE;
                    end
                end
                ARB_XFER: begin
                    if (push_s) begin
                        wd_cnt_q <= '0;
                    end else if (stall_s && (wd_cnt_q != '1)) begin
                        wd_cnt_q <= wd_cnt_q + TOB'(1);
                    end else begin
                        wd_cnt_q <= wd_cnt_q;
                    end

                    if (flush_req_i || wd_fire_s) begin
                        state_q <= ARB_FLUSH;
                    end else if (push_s && own_last_s) begin
                        rr_ptr_q <= (owner_q == OWB'(NREQ - 1)) ? '0 : owner_q + OWB'(1);
                        state_q  <= ARB_IDLE;
                    end else begin
                        state_q <= ARB_XFER;
                    end
                end
                ARB_FLUSH: begin
                    wd_cnt_q <= '0;
                    state_q  <= ARB_RECOV;
                end
                ARB_RECOV: begin
                    wd_cnt_q <= '0;
                    state_q  <= ARB_IDLE;
                end
                default: begin
                    wd_cnt_q <= '0;
                    state_q  <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule : i3c_tb_fifo_arbiter

// File: tb/tb_i3c_tb_fifo_arbiter.sv
// ----------------------------------------------------------------------------
// tb_i3c_tb_fifo_arbiter
// Per-cycle directed vectors for the TX FIFO arbiter (TIMEOUT=4), followed by
// a hand-written asynchronous-reset sequence.
// ----------------------------------------------------------------------------
module tb_i3c_tb_fifo_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [23:0] req_data;
    logic [2:0]  req_last;
    logic [2:0]  req_ready;
    logic        tb_ready;
    logic [7:0]  tb_data;
    logic        tb_end;
    logic        tb_full;
    logic        tb_flush;
    logic        flush_req;
    logic        err_clr;
    logic        busy;
    logic [1:0]  owner;
    logic        msg_done;
    logic        timeout_err;

    logic [18:0] act_s;

    int n_chk;
    int n_err;

    typedef struct {
        logic [2:0]  v;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic [7:0]  d2;
        logic [2:0]  l;
        logic        f;
        logic        fr;
        logic        ec;
        logic [18:0] exp;
    } vec_t;

    vec_t vecs[$];

    i3c_tb_fifo_arbiter #(
        .NREQ    (3),
        .OWB     (2),
        .TIMEOUT (4),
        .TOB     (8)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_valid_i      (req_valid),
        .req_data_i       (req_data),
        .req_last_i       (req_last),
        .req_ready_o      (req_ready),
        .avail_tb_ready_o (tb_ready),
        .avail_tb_data_o  (tb_data),
        .avail_tb_end_o   (tb_end),
        .avail_tb_full_i  (tb_full),
        .tb_flush_o       (tb_flush),
        .flush_req_i      (flush_req),
        .err_clr_i        (err_clr),
        .busy_o           (busy),
        .owner_o          (owner),
        .msg_done_o       (msg_done),
        .timeout_err_o    (timeout_err)
    );

    // Output bundle: {ready[2:0], tb_ready, data[7:0], end, flush, busy, owner[1:0], msg_done, timeout_err}
    assign act_s = {req_ready, tb_ready, tb_data, tb_end, tb_flush, busy, owner, msg_done, timeout_err};

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [18:0] act, input logic [18:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] v, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [2:0] l, input logic f,
                       input logic fr, input logic ec,
                       input logic [2:0] rdy, input logic tr, input logic [7:0] td,
                       input logic te, input logic fl, input logic b,
                       input logic [1:0] o, input logic md, input logic to);
        vec_t t;
        t.v = v; t.d0 = d0; t.d1 = d1; t.d2 = d2; t.l = l;
        t.f = f; t.fr = fr; t.ec = ec;
        t.exp = {rdy, tr, td, te, fl, b, o, md, to};
        vecs.push_back(t);
    endtask

    task automatic drive(input logic [2:0] v, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [2:0] l, input logic f,
                         input logic fr, input logic ec);
        req_valid = v;
        req_data  = {d2, d1, d0};
        req_last  = l;
        tb_full   = f;
        flush_req = fr;
        err_clr   = ec;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0);

        //   v       d0     d1     d2     l       f     fr    ec  | rdy     tr    td     te    fl    b     o      md    to
        // req0 and req2 together from rr_ptr=0: req0 first, then req2 (req0 ignored meanwhile)
        add(3'b101, 8'hB1, 8'h00, 8'hC1, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        add(3'b101, 8'hB1, 8'h00, 8'hC1, 3'b000, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 8'hB1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
        add(3'b101, 8'hB2, 8'h00, 8'hC1, 3'b001, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 8'hB2, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0);
        add(3'b101, 8'hB3, 8'h00, 8'hC1, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        add(3'b101, 8'hB3, 8'h00, 8'hC1, 3'b000, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1, 8'hC1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
        add(3'b101, 8'hB3, 8'h00, 8'hC2, 3'b100, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1, 8'hC2, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0);
        // rr_ptr wrapped to 0: req0 single-byte message
        add(3'b001, 8'hB3, 8'h00, 8'h00, 3'b001, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
        add(3'b001, 8'hB3, 8'h00, 8'h00, 3'b001, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 8'hB3, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0);
        // rr_ptr=1, req0 and req1 valid: req1 granted
        add(3'b011, 8'hB4, 8'hD1, 8'h00, 3'b011, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        add(3'b011, 8'hB4, 8'hD1, 8'h00, 3'b011, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 8'hD1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0);
        // rr_ptr=2, only req0: wrap-around grant, 3-byte message with 5 full cycles
        add(3'b001, 8'hE1, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);
        add(3'b001, 8'hE1, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 8'hE1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            add(3'b001, 8'hE2, 8'h00, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 8'hE2, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
        end
        add(3'b001, 8'hE2, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 8'hE2, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
        add(3'b001, 8'hE3, 8'h00, 8'h00, 3'b001, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 8'hE3, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0);
        // req1 sends one byte then stalls: watchdog fires on 4th stall cycle; err_clr same cycle loses
        add(3'b010, 8'h00, 8'hF1, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        add(3'b010, 8'h00, 8'hF1, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 8'hF1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            add(3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
        end
        add(3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
        // FLUSH then RECOV, flush_req ignored in both, no grant during RECOV
        add(3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1);
        add(3'b010, 8'h00, 8'h11, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1);
        add(3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1);
        add(3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);
        // flush_req with last-byte push: byte written, no msg_done, req1 waits for RECOV
        add(3'b001, 8'hA7, 8'h00, 8'h00, 3'b001, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);
        add(3'b011, 8'hA7, 8'h91, 8'h00, 3'b011, 1'b0, 1'b1, 1'b0, 3'b001, 1'b1, 8'hA7, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
        add(3'b010, 8'h00, 8'h91, 8'h00, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        add(3'b010, 8'h00, 8'h91, 8'h00, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
        add(3'b010, 8'h00, 8'h91, 8'h00, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        add(3'b010, 8'h00, 8'h91, 8'h00, 3'b010, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 8'h91, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0);
        // flush_req from IDLE: FLUSH, RECOV, IDLE
        add(3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);
        add(3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
        add(3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
        add(3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset", act_s, 19'h0);
        rst_n = 1'b1;

        // Table: inputs applied at negedge, outputs sampled 1 unit later
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].l,
                  vecs[i].f, vecs[i].fr, vecs[i].ec);
            #1;
            chk($sformatf("vec%0d", i), act_s, vecs[i].exp);
        end

        // Async reset mid-XFER (rr_ptr is 2 beforehand): req0 granted by wrap
        @(negedge clk);
        drive(3'b001, 8'h55, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("pre_rst_xfer", act_s, {3'b001, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0});
        rst_n = 1'b0;
        #1;
        chk("async_rst", act_s, 19'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'b110, 8'h00, 8'h66, 8'h77, 3'b110, 1'b0, 1'b0, 1'b0);
        #1;
        chk("post_rst_idle", act_s, 19'h0);
        // rr_ptr back at 0: req1 beats req2
        @(negedge clk);
        #1;
        chk("post_rst_grant", act_s, {3'b010, 1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_i3c_tb_fifo_arbiter
